// File: rtl/jump_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl_if
// Description : Bundles the predictor event inputs, the stall input, and the
//               redirect/flush/statistics outputs of jump_redirect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface jump_redirect_ctrl_if;
  logic        stall;
  logic        jump_pred;
  logic [15:0] jump_pred_adr;
  logic        jump_pred_miss;
  logic        jump_pred_adr_miss;
  logic [15:0] pcinc_evac;
  logic [15:0] ALUres_mem;

  logic        pc_redirect;
  logic [15:0] pc_target;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        redirect_busy;
  logic [15:0] cnt_pred;
  logic [15:0] cnt_miss;

  // Controller side
  modport slave (
    input  stall, jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
           pcinc_evac, ALUres_mem,
    output pc_redirect, pc_target, flush_if, flush_id, flush_ex, redirect_busy,
           cnt_pred, cnt_miss
  );

  // Predictor / pipeline side
  modport master (
    output stall, jump_pred, jump_pred_adr, jump_pred_miss, jump_pred_adr_miss,
           pcinc_evac, ALUres_mem,
    input  pc_redirect, pc_target, flush_if, flush_id, flush_ex, redirect_busy,
           cnt_pred, cnt_miss
  );
endinterface
`default_nettype wire

// File: rtl/jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl
// Description : Turns predictor prediction/miss events into a registered PC
//               redirect with latched target, per-stage flush strobes, and
//               saturating prediction/recovery counters.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  jump_redirect_ctrl_if.slave    bus
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic        kind_q, kind_d;          // 0 = predict, 1 = miss
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] cnt_pred_q, cnt_miss_q;

  logic        ev_miss;
  logic        ev_any;
  logic [15:0] ev_target;
  logic        redirect_fire;

  // Event decode with priority adr-miss > miss > prediction
  always_comb begin
    ev_miss   = bus.jump_pred_adr_miss | bus.jump_pred_miss;
    ev_any    = ev_miss | bus.jump_pred;
    ev_target = bus.jump_pred_adr;
    if (bus.jump_pred_adr_miss) begin
      ev_target = bus.ALUres_mem;
    end else if (bus.jump_pred_miss) begin
      ev_target = bus.pcinc_evac;
    end
  end

  // Next-state logic: event latching, stall holding and flush countdown
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    kind_d      = kind_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_any) begin
          target_d = ev_target;
          kind_d   = ev_miss;
          state_d  = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (ev_miss && !kind_q) begin
          // A recovery supersedes a pending prediction
          target_d = ev_target;
          kind_d   = 1'b1;
        end else if (!bus.stall) begin
          if (!kind_q) begin
            if (bus.jump_pred) begin
              // Back-to-back prediction restarts the redirect
              target_d = ev_target;
              kind_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (FLUSH_INIT == 3'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end
      end
      ST_FLUSH: begin
        if (ev_miss) begin
          target_d = ev_target;
          kind_d   = 1'b1;
          state_d  = ST_REDIRECT;
        end else if (!bus.stall) begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched redirect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      target_q    <= 16'h0000;
      kind_q      <= 1'b0;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      kind_q      <= kind_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign redirect_fire = (state_q == ST_REDIRECT) && !bus.stall;

  // Saturating statistics, stepped on each issued redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_pred_q <= 16'h0000;
      cnt_miss_q <= 16'h0000;
    end else if (redirect_fire) begin
      if (kind_q) begin
        if (cnt_miss_q != 16'hFFFF) cnt_miss_q <= cnt_miss_q + 16'd1;
      end else begin
        if (cnt_pred_q != 16'hFFFF) cnt_pred_q <= cnt_pred_q + 16'd1;
      end
    end
  end

  assign bus.pc_redirect   = redirect_fire;
  assign bus.pc_target     = target_q;
  assign bus.flush_if      = (state_q != ST_IDLE);
  assign bus.flush_id      = (state_q == ST_REDIRECT) && kind_q;
  assign bus.flush_ex      = (state_q == ST_REDIRECT) && kind_q;
  assign bus.redirect_busy = (state_q != ST_IDLE);
  assign bus.cnt_pred      = cnt_pred_q;
  assign bus.cnt_miss      = cnt_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_redirect_ctrl
// Description : Directed scoreboard bench for jump_redirect_ctrl
//               (FLUSH_CYCLES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_redirect_ctrl;

  typedef struct {
    logic [15:0] target;
    logic        kind;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   mon_en;
  exp_t sb[$];

  jump_redirect_ctrl_if bus();

  jump_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start of the next cycle, away from the sampling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_events();
    bus.jump_pred          = 1'b0;
    bus.jump_pred_miss     = 1'b0;
    bus.jump_pred_adr_miss = 1'b0;
  endtask

  task automatic push(input logic [15:0] t, input logic k);
    exp_t e;
    e.target = t;
    e.kind   = k;
    sb.push_back(e);
  endtask

  // Checks one cycle: redirect fire, IF flush, ID flush, busy
  task automatic chk_cyc(input string name, input logic pr, input logic fi,
                         input logic fid, input logic bsy);
    #3;
    chk({name, ".pc_redirect"}, {31'd0, bus.pc_redirect}, {31'd0, pr});
    chk({name, ".flush_if"}, {31'd0, bus.flush_if}, {31'd0, fi});
    chk({name, ".flush_id"}, {31'd0, bus.flush_id}, {31'd0, fid});
    chk({name, ".busy"}, {31'd0, bus.redirect_busy}, {31'd0, bsy});
  endtask

  // Monitor: every issued redirect must match the oldest expected entry
  always @(negedge clk) begin
    if (reset && mon_en && bus.pc_redirect) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon.unexpected: got redirect to %h expected none", bus.pc_target);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon.target", {16'd0, bus.pc_target}, {16'd0, e.target});
        chk("mon.flush_id", {31'd0, bus.flush_id}, {31'd0, e.kind});
        chk("mon.flush_ex", {31'd0, bus.flush_ex}, {31'd0, e.kind});
        chk("mon.flush_if", {31'd0, bus.flush_if}, 32'd1);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b1;
    reset    = 1'b0;
    bus.stall = 1'b0;
    clr_events();
    bus.jump_pred_adr = 16'h0000;
    bus.pcinc_evac    = 16'h0000;
    bus.ALUres_mem    = 16'h0000;

    // Reset state
    repeat (2) tick();
    chk("rst.pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    chk("rst.flush_if", {31'd0, bus.flush_if}, 32'd0);
    chk("rst.busy", {31'd0, bus.redirect_busy}, 32'd0);
    chk("rst.pc_target", {16'd0, bus.pc_target}, 32'd0);
    chk("rst.cnt_pred", {16'd0, bus.cnt_pred}, 32'd0);
    reset = 1'b1;

    // Prediction, no stall
    bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0040; push(16'h0040, 1'b0);
    tick(); clr_events(); chk_cyc("pred.c1", 1, 1, 0, 1);
    tick(); chk_cyc("pred.c2", 0, 0, 0, 0);
    chk("pred.cnt_pred", {16'd0, bus.cnt_pred}, 32'd1);

    // Adr-miss with two extra flush cycles
    bus.jump_pred_adr_miss = 1'b1; bus.ALUres_mem = 16'h0123; push(16'h0123, 1'b1);
    tick(); clr_events(); chk_cyc("adrm.c1", 1, 1, 1, 1);
    tick(); chk_cyc("adrm.c2", 0, 1, 0, 1);
    tick(); chk_cyc("adrm.c3", 0, 1, 0, 1);
    tick(); chk_cyc("adrm.c4", 0, 0, 0, 0);
    chk("adrm.cnt_miss", {16'd0, bus.cnt_miss}, 32'd1);

    // Stall hold on a miss redirect
    bus.jump_pred_miss = 1'b1; bus.pcinc_evac = 16'h0011; push(16'h0011, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick(); clr_events(); bus.stall = 1'b1;
      chk_cyc("stall.hold", 0, 1, 1, 1);
      chk("stall.target", {16'd0, bus.pc_target}, 32'h0011);
    end
    tick(); bus.stall = 1'b0; chk_cyc("stall.c4", 1, 1, 1, 1);
    tick(); chk_cyc("stall.c5", 0, 1, 0, 1);
    tick(); chk_cyc("stall.c6", 0, 1, 0, 1);
    tick(); chk_cyc("stall.c7", 0, 0, 0, 0);
    chk("stall.cnt_miss", {16'd0, bus.cnt_miss}, 32'd2);

    // Priority: adr-miss beats a simultaneous prediction
    bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0040;
    bus.jump_pred_adr_miss = 1'b1; bus.ALUres_mem = 16'h0200; push(16'h0200, 1'b1);
    tick(); clr_events(); chk_cyc("prio.c1", 1, 1, 1, 1);
    repeat (3) tick();
    chk("prio.cnt_pred", {16'd0, bus.cnt_pred}, 32'd1);
    chk("prio.cnt_miss", {16'd0, bus.cnt_miss}, 32'd3);

    // Miss overwrites a stalled prediction
    bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0050;
    tick(); clr_events(); bus.stall = 1'b1;
    bus.jump_pred_miss = 1'b1; bus.pcinc_evac = 16'h0077; push(16'h0077, 1'b1);
    chk_cyc("ovr.c1", 0, 1, 0, 1);
    chk("ovr.c1.target", {16'd0, bus.pc_target}, 32'h0050);
    tick(); clr_events(); chk_cyc("ovr.c2", 0, 1, 1, 1);
    chk("ovr.c2.target", {16'd0, bus.pc_target}, 32'h0077);
    tick(); bus.stall = 1'b0; chk_cyc("ovr.c3", 1, 1, 1, 1);
    repeat (3) tick();
    chk("ovr.busy", {31'd0, bus.redirect_busy}, 32'd0);
    chk("ovr.cnt_pred", {16'd0, bus.cnt_pred}, 32'd1);
    chk("ovr.cnt_miss", {16'd0, bus.cnt_miss}, 32'd4);

    // Miss during FLUSH re-latches; prediction during FLUSH ignored
    bus.jump_pred_miss = 1'b1; bus.pcinc_evac = 16'h0100; push(16'h0100, 1'b1);
    tick(); clr_events();                       // REDIRECT
    tick();                                     // FLUSH
    bus.jump_pred_adr_miss = 1'b1; bus.ALUres_mem = 16'h0300; push(16'h0300, 1'b1);
    chk_cyc("rel.c2", 0, 1, 0, 1);
    tick(); clr_events(); chk_cyc("rel.c3", 1, 1, 1, 1);
    tick();                                     // FLUSH cnt 2
    tick(); bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0999;   // FLUSH cnt 1
    tick(); clr_events(); chk_cyc("rel.c6", 0, 0, 0, 0);
    chk("rel.cnt_miss", {16'd0, bus.cnt_miss}, 32'd6);
    chk("rel.cnt_pred", {16'd0, bus.cnt_pred}, 32'd1);

    // Back-to-back predictions
    bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0A00; push(16'h0A00, 1'b0);
    tick(); bus.jump_pred_adr = 16'h0A10; push(16'h0A10, 1'b0);
    chk_cyc("b2b.c1", 1, 1, 0, 1);
    tick(); clr_events(); chk_cyc("b2b.c2", 1, 1, 0, 1);
    tick(); chk_cyc("b2b.c3", 0, 0, 0, 0);
    chk("b2b.cnt_pred", {16'd0, bus.cnt_pred}, 32'd3);
    chk("sb.drained", sb.size(), 32'd0);

    // Saturation of the prediction counter
    mon_en = 1'b0;
    bus.jump_pred = 1'b1; bus.jump_pred_adr = 16'h0C00;
    repeat (65540) tick();
    clr_events();
    tick(); tick();
    chk("sat.cnt_pred", {16'd0, bus.cnt_pred}, 32'h0000FFFF);
    chk("sat.cnt_miss", {16'd0, bus.cnt_miss}, 32'd6);
    chk("sat.busy", {31'd0, bus.redirect_busy}, 32'd0);
    mon_en = 1'b1;

    // Asynchronous reset in the middle of FLUSH
    bus.jump_pred_miss = 1'b1; bus.pcinc_evac = 16'h0555; push(16'h0555, 1'b1);
    tick(); clr_events();                       // REDIRECT
    tick(); #2;                                 // FLUSH, mid-cycle
    chk("ar.pre_flush_if", {31'd0, bus.flush_if}, 32'd1);
    reset = 1'b0;
    #1;
    chk("ar.flush_if", {31'd0, bus.flush_if}, 32'd0);
    chk("ar.busy", {31'd0, bus.redirect_busy}, 32'd0);
    chk("ar.cnt_pred", {16'd0, bus.cnt_pred}, 32'd0);
    chk("ar.cnt_miss", {16'd0, bus.cnt_miss}, 32'd0);
    chk("ar.target", {16'd0, bus.pc_target}, 32'd0);
    tick(); reset = 1'b1;
    tick(); chk_cyc("ar.after", 0, 0, 0, 0);
    chk("ar.sb.drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jump_redirect_ctrl.md
# jump_redirect_ctrl

Sequencer sitting between `jumppred` and the fetch/pipeline-register logic. It turns the predictor's prediction and miss indications into a registered PC-redirect command with a latched target, plus per-stage flush strobes that kill wrong-path instructions. It honours pipeline stalls and keeps saturating prediction/miss statistics for debug readout.

## Interface
- `FLUSH_CYCLES`, default 1: extra cycles `flush_if` stays asserted after a miss redirect (range 0–7).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  pipeline stall from hazard unit; blocks PC load.
- `jump_pred`  in  1  predictor redirects fetch (ID-stage prediction).
- `jump_pred_adr`  in  16  predicted target.
- `jump_pred_miss`  in  1  predicted taken, actually not taken.
- `jump_pred_adr_miss`  in  1  actually taken, but unpredicted or wrong target.
- `pcinc_evac`  in  16  fall-through PC of the predicted branch.
- `ALUres_mem`  in  16  resolved branch target.
- `pc_redirect`  out  1  load `pc_target` into PC this cycle.
- `pc_target`  out  16  redirect address.
- `flush_if`, `flush_id`, `flush_ex`  out  1 each  squash the IF/ID, ID/EX, EX/MEM register contents.
- `redirect_busy`  out  1  FSM not in IDLE.
- `cnt_pred`  out  16  predictions issued, saturating.
- `cnt_miss`  out  16  recoveries issued, saturating.

## Operation
- FSM states: IDLE, REDIRECT, FLUSH. Registers: `state`, `pc_target`, `kind` (0 = predict, 1 = miss), 3-bit `flush_cnt`, counters.
- Event priority, highest first:
  - `jump_pred_adr_miss`: target = `ALUres_mem`, kind = miss.
  - `jump_pred_miss`: target = `pcinc_evac`, kind = miss.
  - `jump_pred`: target = `jump_pred_adr`, kind = predict.
- Events are sampled every cycle regardless of `stall`.
- IDLE, on any event: latch target and kind, go to REDIRECT.
- REDIRECT:
  - `pc_redirect = !stall`.
  - `flush_if = 1`.
  - `flush_id = flush_ex = kind`.
  - If `stall`, hold the state.
  - Otherwise: kind = predict goes to IDLE; kind = miss goes to FLUSH with `flush_cnt = FLUSH_CYCLES`, or to IDLE if `FLUSH_CYCLES == 0`.
  - A miss event arriving in REDIRECT while kind = predict overwrites target and kind and stays in REDIRECT; the pending prediction is dropped.
  - A miss event arriving while kind = miss is ignored.
- FLUSH:
  - `flush_if = 1`; `pc_redirect`, `flush_id`, `flush_ex` are 0.
  - `flush_cnt` decrements only when `!stall`; go to IDLE when it reaches 1 and `!stall`.
  - A miss event in FLUSH re-latches and goes to REDIRECT.
  - `jump_pred` in FLUSH is ignored.
- `redirect_busy = (state != IDLE)`.
- Counters increment when `pc_redirect` fires: `cnt_pred` for kind = predict, `cnt_miss` for kind = miss. Each saturates at 16'hFFFF and does not wrap.
- All outputs are combinational from registered state and `stall` only. No input-to-output combinational path except through `stall`.

## Timing
- Reset (async assert, `reset` = 0): state IDLE, `pc_target` = 0, kind = 0, `flush_cnt` = 0, counters = 0. All 1-bit outputs are 0 immediately, without a clock.
- Reset deasserts synchronously to the design; the first event is sampled on the first rising edge with `reset` = 1.
- Latency: event sampled at the edge ending cycle t; `pc_redirect` is high in cycle t+1 if `stall` = 0.
- A stall of n cycles delays `pc_redirect` by n cycles. Target and flush strobes hold steady throughout.
- A miss redirect occupies 1 + `FLUSH_CYCLES` unstalled cycles. A prediction redirect occupies 1.
- Back-to-back predictions: an event in the `pc_redirect` cycle of a predict redirect is sampled and starts a new REDIRECT next cycle.
- Reset mid-REDIRECT or mid-FLUSH: the redirect is abandoned and no counter update occurs.

## Test plan
- Prediction, no stall: `jump_pred` = 1, `jump_pred_adr` = 16'h0040 in cycle 0 → cycle 1: `pc_redirect` = 1, `pc_target` = 16'h0040, `flush_if` = 1, `flush_id` = `flush_ex` = 0; cycle 2 IDLE; `cnt_pred` = 1.
- Adr-miss with `FLUSH_CYCLES` = 2: `jump_pred_adr_miss` = 1, `ALUres_mem` = 16'h0123 → cycle 1: all three flushes and `pc_redirect`, target 16'h0123; cycles 2–3: `flush_if` only; cycle 4 IDLE; `cnt_miss` = 1.
- Stall hold: `jump_pred_miss`, `pcinc_evac` = 16'h0011, `stall` = 1 for cycles 1–3 → `pc_redirect` = 0 and `pc_target` = 16'h0011 held during cycles 1–3; `pc_redirect` = 1 in cycle 4.
- Priority: `jump_pred` (16'h0040) and `jump_pred_adr_miss` (16'h0200) in the same cycle → target 16'h0200, kind = miss, `cnt_pred` unchanged. Then a miss arriving in the stalled REDIRECT of a prediction replaces it.
- Saturation: force 65 536 prediction redirects → `cnt_pred` stays 16'hFFFF.
- Async reset: assert `reset` = 0 mid-FLUSH between clock edges → `flush_if` and `redirect_busy` drop immediately; counters read 0.
